grid_tile_framebuffer: RTL and testbench

//  Tile framebuffer between the Arduino SPI receiver and the VGA driver.
//  - Stores one 8-bit RGB332 colour per maze tile, on a GRID_W x GRID_H grid.
//  - Write side: 24-bit {x,y,colour} words strobed from spi_slave.
//  - Read side: maps VGA pixel coords to a tile and returns its colour, 1-cycle latency.
//  - Replaces the per-register flop array with one inferred RAM and a clear sweeper.

---
 rtl/grid_tile_framebuffer.sv | 111 +++++++++++
 tb/tb_grid_tile_framebuffer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/grid_tile_framebuffer.sv
// Tile framebuffer: one RGB332 colour per maze tile in an inferred RAM, written from the
// SPI receiver and read by the VGA driver with one cycle of latency; cleared by a sweeper.
module grid_tile_framebuffer #(
  parameter int          GRID_W      = 64,
  parameter int          GRID_H      = 32,
  parameter int          TILE_W      = 10,
  parameter int          TILE_H      = 15,
  parameter logic [7:0]  CLEAR_COLOR = 8'h00,
  parameter logic [7:0]  OUT_COLOR   = 8'h00
) (
  input  logic        CLOCK_25,
  input  logic        reset,
  input  logic        wr_valid,
  input  logic [23:0] wr_data,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  output logic [7:0]  pixel_color,
  output logic        busy,
  output logic [7:0]  drop_count
);

  localparam int XW    = $clog2(GRID_W);
  localparam int YW    = $clog2(GRID_H);
  localparam int AW    = XW + YW;
  localparam int DEPTH = GRID_W * GRID_H;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam int unsigned GRID_W_U = GRID_W;
  localparam int unsigned GRID_H_U = GRID_H;
  localparam int unsigned X_LIMIT  = GRID_W * TILE_W;
  localparam int unsigned Y_LIMIT  = GRID_H * TILE_H;

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t          state_reg, state_next;
  logic [AW-1:0]   clr_addr_reg, clr_addr_next;

  always_ff @(posedge CLOCK_25) begin
    if (reset) begin
      state_reg    <= ST_CLEAR;
      clr_addr_reg <= '0;
    end else begin
      state_reg    <= state_next;
      clr_addr_reg <= clr_addr_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    clr_addr_next = clr_addr_reg;
    if (state_reg == ST_CLEAR) begin
      clr_addr_next = clr_addr_reg + 1'b1;
      if (clr_addr_reg == LAST_ADDR) state_next = ST_RUN;
    end
  end

  assign busy = (state_reg == ST_CLEAR);

  // Write side: the clear sweep owns the RAM port while busy.
  logic [7:0]    wx, wy;
  logic          wr_in_range, wr_accept, wr_reject, we;
  logic [AW-1:0] waddr;
  logic [7:0]    wdata;

  assign wx          = wr_data[23:16];
  assign wy          = wr_data[15:8];
  assign wr_in_range = (32'(wx) < GRID_W_U) && (32'(wy) < GRID_H_U);
  assign wr_accept   = wr_valid && !busy && wr_in_range;
  assign wr_reject   = wr_valid && !wr_accept;
  assign we          = busy || wr_accept;
  assign waddr       = busy ? clr_addr_reg : {wy[YW-1:0], wx[XW-1:0]};
  assign wdata       = busy ? CLEAR_COLOR : wr_data[7:0];

  // Read side: pixel -> tile by constant divide; out-of-range pixels read address 0.
  logic [XW-1:0] tx;
  logic [YW-1:0] ty;
  logic          oob;
  logic [AW-1:0] rd_addr;

  assign tx      = XW'(pix_x / 10'(TILE_W));
  assign ty      = YW'(pix_y / 10'(TILE_H));
  assign oob     = (32'(pix_x) >= X_LIMIT) || (32'(pix_y) >= Y_LIMIT);
  assign rd_addr = oob ? '0 : {ty, tx};

  logic [7:0] mem [DEPTH];
  logic [7:0] ram_q;

  always_ff @(posedge CLOCK_25) begin
    if (we) mem[waddr] <= wdata;
    ram_q <= mem[rd_addr];
  end

  logic       oob_reg, clear_reg;
  logic [7:0] drop_count_reg;

  always_ff @(posedge CLOCK_25) begin
    if (reset) begin
      oob_reg        <= 1'b0;
      clear_reg      <= 1'b1;
      drop_count_reg <= 8'h00;
    end else begin
      oob_reg   <= oob;
      clear_reg <= busy;
      if (wr_reject && drop_count_reg != 8'hFF) drop_count_reg <= drop_count_reg + 8'h01;
    end
  end

  // clear_reg masks reads issued during the sweep, including its final cycle.
  assign pixel_color = clear_reg ? CLEAR_COLOR : (oob_reg ? OUT_COLOR : ram_q);
  assign drop_count  = drop_count_reg;

endmodule

// File: tb/tb_grid_tile_framebuffer.sv
// Scoreboard bench for grid_tile_framebuffer: probes push expected colours, a monitor
// pops them one cycle later; status outputs are checked directly.
module tb_grid_tile_framebuffer;

  localparam logic [7:0] OUTC = 8'hA5;

  logic        CLOCK_25 = 1'b0;
  logic        reset    = 1'b1;
  logic        wr_valid = 1'b0;
  logic [23:0] wr_data  = '0;
  logic [9:0]  pix_x    = '0;
  logic [9:0]  pix_y    = '0;
  logic [7:0]  pixel_color;
  logic        busy;
  logic [7:0]  drop_count;

  grid_tile_framebuffer #(.OUT_COLOR(OUTC)) dut (
    .CLOCK_25    (CLOCK_25),
    .reset       (reset),
    .wr_valid    (wr_valid),
    .wr_data     (wr_data),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .pixel_color (pixel_color),
    .busy        (busy),
    .drop_count  (drop_count)
  );

  always #20 CLOCK_25 = ~CLOCK_25;

  typedef struct {
    logic [7:0] exp;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  logic probe_v = 1'b0;
  logic v_d = 1'b0;

  always @(posedge CLOCK_25) v_d <= probe_v;

  always @(negedge CLOCK_25) begin
    if (v_d) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_read: got %02h, scoreboard empty", pixel_color);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (pixel_color !== e.exp) begin
          bad++;
          $display("FAIL %s: got %02h, want %02h", e.name, pixel_color, e.exp);
        end else begin
          $display("read %s: %02h", e.name, pixel_color);
        end
      end
    end
  end

  task automatic check(input string n, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", n, got, want);
    end else begin
      $display("check %s: %0h", n, got);
    end
  endtask

  task automatic probe(input logic [9:0] x, input logic [9:0] y, input logic [7:0] e,
                       input string n);
    exp_t t;
    t.exp = e;
    t.name = n;
    pix_x = x;
    pix_y = y;
    probe_v = 1'b1;
    sb.push_back(t);
    @(negedge CLOCK_25);
    probe_v = 1'b0;
  endtask

  task automatic write(input logic [23:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    @(negedge CLOCK_25);
    wr_valid = 1'b0;
  endtask

  task automatic count_busy(input string n);
    int cnt = 0;
    while (busy === 1'b1 && cnt < 5000) begin
      cnt++;
      @(negedge CLOCK_25);
    end
    check(n, cnt, 2048);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge CLOCK_25);
    reset = 1'b0;
  endtask

  initial begin
    // 1: reset state and sweep length
    repeat (2) @(negedge CLOCK_25);
    reset = 1'b0;
    check("reset_busy", 32'(busy), 1);
    check("reset_drop", 32'(drop_count), 0);
    check("reset_color", 32'(pixel_color), 0);
    count_busy("sweep_len");
    probe(0, 0, 8'h00, "after_clear_0_0");

    // 2: basic write and read back
    write(24'h03_02_E0);
    probe(35, 30, 8'hE0, "tile_3_2");
    probe(29, 30, 8'h00, "tile_2_2");

    // 3: tile edges
    write(24'h03_02_1C);
    probe(39, 44, 8'h1C, "edge_39_44");
    probe(40, 44, 8'h00, "edge_40_44");
    probe(39, 45, 8'h00, "edge_39_45");

    // 4: rejected writes and saturation
    write(24'h40_00_FF);
    write(24'h00_20_FF);
    check("drop_two", 32'(drop_count), 2);
    probe(0, 0, 8'h00, "unchanged_0_0");
    probe(35, 30, 8'h1C, "unchanged_3_2");
    wr_valid = 1'b1;
    wr_data  = 24'hFF_FF_00;
    repeat (300) @(negedge CLOCK_25);
    wr_valid = 1'b0;
    check("drop_sat", 32'(drop_count), 32'hFF);

    // 6: out-of-range pixels and read-before-write collision
    probe(640, 0, OUTC, "oob_x");
    probe(0, 480, OUTC, "oob_y");
    probe(639, 479, 8'h00, "last_tile");
    write(24'h00_00_77);
    probe(0, 0, 8'h77, "tile_0_0");
    wr_valid = 1'b1;
    wr_data  = 24'h00_00_03;
    probe(0, 0, 8'h77, "collide_old");
    wr_valid = 1'b0;
    probe(0, 0, 8'h03, "collide_new");
    probe(640, 0, OUTC, "oob_masks_ram");

    // 5: write during clear, reset mid-sweep
    pulse_reset();
    check("reclear_drop", 32'(drop_count), 0);
    repeat (99) @(negedge CLOCK_25);
    write(24'h00_00_55);
    check("clear_drop", 32'(drop_count), 1);
    probe(35, 30, 8'h00, "clear_masks");
    repeat (896) @(negedge CLOCK_25);
    check("mid_busy", 32'(busy), 1);
    pulse_reset();
    count_busy("restart_len");
    probe(35, 30, 8'h00, "recleared_3_2");
    probe(0, 0, 8'h00, "recleared_0_0");

    repeat (3) @(negedge CLOCK_25);
    check("sb_drained", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
